// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with configurable frame format feeding a first-word-fall-through FIFO.
// Optional flow control output rts is built only when UART_RX_RTS_EN is defined.
module uart_rx_fifo #(
  parameter int CLK_FRQ    = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_RX_RTS_EN
  , output logic                        rts
`endif
);

  localparam int DIV   = (CLK_FRQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int B_W   = $clog2(DATA_BITS);
  localparam int P_W   = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [P_W:0]     FULL_CNT = (P_W + 1)'(FIFO_DEPTH);

  if (RTS_MARGIN < 0 || RTS_MARGIN >= FIFO_DEPTH) begin : g_bad_margin
    $error("RTS_MARGIN must lie in 0..FIFO_DEPTH-1");
  end

  typedef enum logic [2:0] {
    ST_WAIT_IDLE, ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP
  } state_t;

  state_t               state;
  logic                 rx_q1, rx_s;
  logic [DIV_W-1:0]     div;
  logic [S_W-1:0]       s;
  logic [B_W-1:0]       bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, stop_bad;
  logic [P_W-1:0]       wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic tick, mid, bit_end, start_det, complete, push, pop, full, wr_en;

  always_comb begin
    tick      = (div == DIV_LAST);
    mid       = tick && (s == S_MID);
    bit_end   = tick && (s == S_LAST);
    start_det = (state == ST_IDLE) && !rx_s;
    complete  = (state == ST_STOP) && mid && (stop_idx == STOP_LAST);
    push      = complete && rx_s && !stop_bad && !par_bad;
    pop       = rd_valid && rd_ready;
    full      = (count == FULL_CNT);
    wr_en     = push && (!full || pop);
    busy      = (state != ST_IDLE) && (state != ST_WAIT_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  div <= '0;
    else if (start_det || tick) div <= '0;
    else                        div <= div + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_WAIT_IDLE;
      s          <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (tick) s <= (s == S_LAST) ? '0 : s + 1'b1;
      unique case (state)
        ST_WAIT_IDLE: if (rx_s) state <= ST_IDLE;
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            s     <= '0;
          end
        end
        ST_START: begin
          if (mid && rx_s) state <= ST_IDLE;
          else if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (mid) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == B_LAST) begin
              state    <= (PARITY == 0) ? ST_STOP : ST_PAR;
              stop_idx <= 1'b0;
              stop_bad <= 1'b0;
              par_bad  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (mid) par_bad <= ((rx_s ^ (^shreg)) != (PARITY == 2));
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          // The last stop bit finishes the frame at its mid-point, so a
          // following start edge is never missed under baud skew.
          if (complete) begin
            if (!rx_s || stop_bad) begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              overrun <= full && !pop;
              state   <= ST_IDLE;
            end
          end else begin
            if (mid && !rx_s) stop_bad <= 1'b1;
            if (bit_end) stop_idx <= 1'b1;
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_valid = (count != '0);
    rd_data  = '0;
    if (rd_valid) rd_data = mem[rd_ptr];
  end

`ifdef UART_RX_RTS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rts <= 1'b0;
    else       rts <= (FIFO_DEPTH - int'(count)) > RTS_MARGIN;
  end
`endif

endmodule
